// File: rtl/ap_ctrl_initiator.sv
// Batch initiator for an ap_ctrl_chain kernel: issues cmd_count starts, bounded by MAX_OUT in flight.
// Optional batch latency measurement is enabled by defining AP_CTRL_INIT_LATENCY_EN.
module ap_ctrl_initiator #(
  parameter int CNT_W   = 16,
  parameter int MAX_OUT = 4,
  parameter int LAT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  input  logic             cont_stall,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic [CNT_W-1:0] txn_started,
  output logic [CNT_W-1:0] txn_done,
  output logic             all_done,
  output logic [LAT_W-1:0] batch_lat
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cmd_count;
  logic [CNT_W-1:0] r_txn_started;
  logic [CNT_W-1:0] r_txn_done;
  logic [OUT_W-1:0] r_outstanding;
  logic             r_all_done;
  logic             w_start_hs;
  logic             w_done_hs;
  logic             w_accept;
  logic             w_zero_cmd;
  logic             w_finish;
  logic [CNT_W-1:0] w_started_next;
  logic [CNT_W-1:0] w_done_next;

  assign cmd_ready   = (r_state == IDLE);
  assign ap_start    = (r_state == RUN) && (r_txn_started < r_cmd_count) &&
                       (r_outstanding < OUT_W'(MAX_OUT));
  assign ap_continue = (r_state != IDLE) && !cont_stall;

  // A done can only belong to an invocation that was already started.
  assign w_start_hs     = ap_start && ap_ready;
  assign w_done_hs      = ap_done && ap_continue && (r_txn_done < r_txn_started);
  assign w_started_next = r_txn_started + CNT_W'(w_start_hs);
  assign w_done_next    = r_txn_done + CNT_W'(w_done_hs);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_zero_cmd   = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_count != '0) begin
            w_accept     = 1'b1;
            w_state_next = RUN;
          end else begin
            w_zero_cmd = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_done_next == r_cmd_count) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end else if (w_started_next == r_cmd_count) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_done_next == r_cmd_count) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cmd_count   <= '0;
      r_txn_started <= '0;
      r_txn_done    <= '0;
      r_outstanding <= '0;
      r_all_done    <= 1'b0;
    end else begin
      r_all_done <= w_finish || w_zero_cmd;
      if (w_accept) begin
        r_cmd_count   <= cmd_count;
        r_txn_started <= '0;
        r_txn_done    <= '0;
        r_outstanding <= '0;
      end else if (r_state != IDLE) begin
        r_txn_started <= w_started_next;
        r_txn_done    <= w_done_next;
        case ({w_start_hs, w_done_hs})
          2'b10:   r_outstanding <= r_outstanding + 1'b1;
          2'b01:   r_outstanding <= r_outstanding - 1'b1;
          default: r_outstanding <= r_outstanding;
        endcase
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign txn_started = r_txn_started;
  assign txn_done    = r_txn_done;
  assign all_done    = r_all_done;

`ifdef AP_CTRL_INIT_LATENCY_EN
  logic [LAT_W-1:0] r_lat_cnt;
  logic [LAT_W-1:0] r_batch_lat;
  logic [LAT_W-1:0] w_lat_inc;

  // The finishing cycle itself is counted, hence the incremented value on load.
  assign w_lat_inc = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lat_cnt   <= '0;
      r_batch_lat <= '0;
    end else begin
      if (w_accept)               r_lat_cnt <= '0;
      else if (r_state != IDLE)   r_lat_cnt <= w_lat_inc;
      if (w_finish)               r_batch_lat <= w_lat_inc;
    end
  end

  assign batch_lat = r_batch_lat;
`else
  assign batch_lat = '0;
`endif

endmodule

// File: tb/tb_ap_ctrl_initiator.sv
// Directed bench for ap_ctrl_initiator: a kernel model answers starts with delayed dones,
// and a scoreboard holds the expected final txn_done of each issued batch.
module tb_ap_ctrl_initiator;
  localparam int CNT_W = 16;
  localparam int LAT_W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             sel;
  logic             cmd_valid;
  logic [CNT_W-1:0] cmd_count;
  logic             cont_stall;
  logic             ap_ready;
  logic             ap_done;

  logic             a_cmd_ready, a_ap_start, a_ap_continue, a_busy, a_all_done;
  logic [CNT_W-1:0] a_txn_started, a_txn_done;
  logic [LAT_W-1:0] a_batch_lat;
  logic             b_cmd_ready, b_ap_start, b_ap_continue, b_busy, b_all_done;
  logic [CNT_W-1:0] b_txn_started, b_txn_done;
  logic [LAT_W-1:0] b_batch_lat;

  logic             m_cmd_ready, m_ap_start, m_ap_continue, m_busy, m_all_done;
  logic [CNT_W-1:0] m_txn_started, m_txn_done;
  logic [LAT_W-1:0] m_batch_lat;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int kern_dly = 2;
  int kq[$];
  int sb_q[$];
  int start_cyc[$];
  int done_cyc[$];

  always #5 clock = ~clock;

  ap_ctrl_initiator #(.CNT_W(CNT_W), .MAX_OUT(4), .LAT_W(LAT_W)) u_a (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid && !sel), .cmd_count(cmd_count),
    .cmd_ready(a_cmd_ready), .cont_stall(cont_stall), .ap_start(a_ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(a_ap_continue), .busy(a_busy),
    .txn_started(a_txn_started), .txn_done(a_txn_done), .all_done(a_all_done),
    .batch_lat(a_batch_lat)
  );

  ap_ctrl_initiator #(.CNT_W(CNT_W), .MAX_OUT(1), .LAT_W(LAT_W)) u_b (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid && sel), .cmd_count(cmd_count),
    .cmd_ready(b_cmd_ready), .cont_stall(cont_stall), .ap_start(b_ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(b_ap_continue), .busy(b_busy),
    .txn_started(b_txn_started), .txn_done(b_txn_done), .all_done(b_all_done),
    .batch_lat(b_batch_lat)
  );

  assign m_cmd_ready   = sel ? b_cmd_ready   : a_cmd_ready;
  assign m_ap_start    = sel ? b_ap_start    : a_ap_start;
  assign m_ap_continue = sel ? b_ap_continue : a_ap_continue;
  assign m_busy        = sel ? b_busy        : a_busy;
  assign m_all_done    = sel ? b_all_done    : a_all_done;
  assign m_txn_started = sel ? b_txn_started : a_txn_started;
  assign m_txn_done    = sel ? b_txn_done    : a_txn_done;
  assign m_batch_lat   = sel ? b_batch_lat   : a_batch_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; the kernel model holds ap_done until the done handshake is taken.
  task automatic tick();
    logic s_hs;
    logic d_hs;
    int   c0;
    #1;
    s_hs = m_ap_start && ap_ready;
    d_hs = ap_done && m_ap_continue;
    c0   = cycle;
    @(posedge clock);
    #1;
    cycle++;
    if (d_hs && kq.size() > 0) begin
      void'(kq.pop_front());
      done_cyc.push_back(c0);
    end
    if (s_hs) begin
      kq.push_back(c0 + kern_dly);
      start_cyc.push_back(c0);
    end
    ap_done = (kq.size() > 0) && (kq[0] <= cycle);
  endtask

  task automatic issue(input int cnt, input int exp_done);
    cmd_valid = 1'b1;
    cmd_count = CNT_W'(cnt);
    #1;
    chk("cmd_ready_idle", m_cmd_ready, 1);
    sb_q.push_back(exp_done);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_batch(input int budget);
    int n;
    int exp;
    n = 0;
    while (!m_all_done && n < budget) begin
      tick();
      n++;
    end
    chk("all_done_seen", m_all_done, 1);
    if (m_all_done && sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk("txn_done_final", m_txn_done, exp);
      chk("txn_started_final", m_txn_started, exp);
    end
    tick();
    chk("all_done_one_cycle", m_all_done, 0);
    chk("busy_after_batch", m_busy, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_count = '0;
    cont_stall = 1'b0; ap_ready = 1'b1; ap_done = 1'b0;
    tick(); tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_cmd_ready", a_cmd_ready, 1);
    chk("rst_ap_start", a_ap_start, 0);
    chk("rst_ap_continue", a_ap_continue, 0);
    chk("rst_started", a_txn_started, 0);
    chk("rst_done", a_txn_done, 0);
    chk("rst_all_done", a_all_done, 0);
    chk("rst_batch_lat", a_batch_lat, 0);
    reset = 1'b0;
    tick();

    // Three starts back to back; third start coincides with the first done.
    start_cyc.delete(); done_cyc.delete();
    issue(3, 3);
    tick(); tick();
    chk("overlap_ap_start", m_ap_start, 1);
    chk("overlap_ap_done", ap_done, 1);
    chk("overlap_ap_continue", m_ap_continue, 1);
    chk("overlap_outst_pre", u_a.r_outstanding, 2);
    tick();
    chk("overlap_started", m_txn_started, 3);
    chk("overlap_done", m_txn_done, 1);
    chk("overlap_outst_post", u_a.r_outstanding, 2);
    chk("drain_ap_start", m_ap_start, 0);
    chk("drain_busy", m_busy, 1);
    finish_batch(20);
    chk("b3_start_count", start_cyc.size(), 3);
    if (start_cyc.size() == 3) chk("b3_consecutive", start_cyc[2] - start_cyc[0], 2);
    chk("batch_lat_off", m_batch_lat, 0);

    // MAX_OUT=1: the second start waits for the first done handshake.
    sel = 1'b1;
    start_cyc.delete(); done_cyc.delete();
    issue(2, 2);
    finish_batch(30);
    chk("m1_start_count", start_cyc.size(), 2);
    if (start_cyc.size() == 2 && done_cyc.size() > 0)
      chk("m1_start_after_done", start_cyc[1] > done_cyc[0], 1);
    sel = 1'b0;

    // Backpressure: done held while ap_continue is withheld.
    cont_stall = 1'b1;
    issue(1, 1);
    n = 0;
    while (!ap_done && n < 10) begin
      tick();
      n++;
    end
    chk("stall_done_seen", ap_done, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ap_continue", m_ap_continue, 0);
      chk("stall_txn_done", m_txn_done, 0);
      tick();
    end
    cont_stall = 1'b0;
    #1;
    chk("release_ap_continue", m_ap_continue, 1);
    tick();
    chk("release_txn_done", m_txn_done, 1);
    finish_batch(5);

    // Zero-length batch: immediate all_done, counters untouched.
    start_cyc.delete();
    issue(0, 1);
    chk("zero_all_done", m_all_done, 1);
    chk("zero_busy", m_busy, 0);
    chk("zero_ap_start", m_ap_start, 0);
    finish_batch(1);
    chk("zero_no_start", start_cyc.size(), 0);

    // Reset mid-batch after two of five starts.
    kern_dly = 10;
    issue(5, 5);
    tick(); tick();
    chk("pre_rst_started", m_txn_started, 2);
    reset = 1'b1;
    tick();
    kq.delete();
    ap_done = 1'b0;
    void'(sb_q.pop_back());
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_ap_start", m_ap_start, 0);
    chk("mid_rst_ap_continue", m_ap_continue, 0);
    chk("mid_rst_started", m_txn_started, 0);
    chk("mid_rst_done", m_txn_done, 0);
    chk("mid_rst_outst", u_a.r_outstanding, 0);
    chk("mid_rst_all_done", m_all_done, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_all_done", m_all_done, 0);
    chk("post_rst_cmd_ready", m_cmd_ready, 1);
    kern_dly = 2;
    issue(1, 1);
    finish_batch(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ap_ctrl_initiator.md
AP_CTRL_INITIATOR -- requirements
Module: ap_ctrl_initiator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CNT_W, 16, width of the invocation count and the progress counters.
- MAX_OUT, 4, maximum number of started but not yet completed invocations (1..255).
- LAT_W, 32, width of the batch latency counter.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  batch request.
- cmd_count  in  CNT_W  number of kernel invocations in the batch.
- cmd_ready  out  1  initiator accepts a batch.
- cont_stall  in  1  downstream backpressure; withholds ap_continue.
- ap_start  out  1  kernel start (ap_ctrl_chain).
- ap_ready  in  1  kernel accepted the start.
- ap_done  in  1  kernel completed an invocation.
- ap_continue  out  1  completion acknowledge.
- busy  out  1  batch in progress.
- txn_started  out  CNT_W  handshakes with ap_start and ap_ready both high in this batch.
- txn_done  out  CNT_W  handshakes with ap_done and ap_continue both high in this batch.
- all_done  out  1  one-cycle pulse when the batch finishes.
- batch_lat  out  LAT_W  cycles of the last batch (see Configuration).

Function
REQ-003 The FSM SHALL have the states IDLE, RUN and DRAIN, and all outputs SHALL be registered except ap_start, ap_continue and cmd_ready, which SHALL decode state and counters combinationally.
REQ-004 In IDLE, cmd_ready SHALL be 1, and cmd_valid with cmd_count!=0 SHALL:
- latch cmd_count;
- clear txn_started, txn_done and outstanding;
- enter RUN on the next cycle.
REQ-005 cmd_valid with cmd_count==0 in IDLE SHALL pulse all_done in the next cycle, stay in IDLE and leave the counters unchanged.
REQ-006 In RUN, ap_start SHALL be 1 while txn_started<cmd_count and outstanding<MAX_OUT, and 0 otherwise.
REQ-007 A start handshake (ap_start and ap_ready high) SHALL increment txn_started and outstanding in the same edge.
REQ-008 ap_continue SHALL equal !cont_stall in RUN and DRAIN, and 0 in IDLE.
REQ-009 A done handshake (ap_done and ap_continue high) SHALL increment txn_done and decrement outstanding.
REQ-010 ap_done while ap_continue is 0 SHALL NOT be counted.
REQ-011 A start handshake and a done handshake in the same cycle SHALL both be counted, leaving outstanding unchanged.
REQ-012 RUN SHALL move to DRAIN on the edge at which txn_started reaches cmd_count.
REQ-013 DRAIN SHALL hold ap_start at 0 and SHALL move to IDLE, pulsing all_done one cycle, on the edge at which txn_done reaches cmd_count, including the case where the final start and done handshakes fall in the same cycle.
REQ-014 busy SHALL be 1 exactly in RUN and DRAIN.
REQ-015 cmd_valid SHALL be ignored outside IDLE.
REQ-016 All counter arithmetic SHALL be unsigned and non-wrapping; txn_done>txn_started is impossible by construction.

Reset
REQ-017 reset SHALL, at the next rising edge, force IDLE and clear txn_started, txn_done, outstanding, all_done and batch_lat.
REQ-018 ap_start and ap_continue SHALL be 0 from that edge onwards.
REQ-019 A reset asserted mid-batch SHALL abandon the batch with no all_done pulse.
REQ-020 reset SHALL have priority over every other event in the same cycle.

Configuration
REQ-021 With AP_CTRL_INIT_LATENCY_EN defined:
- the batch latency counter SHALL clear on batch acceptance;
- it SHALL increment every cycle in RUN and DRAIN, saturating at all-ones;
- batch_lat SHALL load its final value on the all_done edge, so a batch of one invocation with ready=start cycle and done two cycles later yields batch_lat = total RUN+DRAIN cycles.
REQ-022 Without AP_CTRL_INIT_LATENCY_EN, the batch latency counter SHALL NOT be synthesised and batch_lat SHALL be constant 0.

Verification
REQ-023 A bench SHALL cover: cmd_count=3, MAX_OUT=4, ap_ready tied high, ap_done 2 cycles after each start -> three start handshakes on consecutive cycles, txn_done=3, one all_done pulse, busy then low.
REQ-024 A bench SHALL cover: MAX_OUT=1, cmd_count=2 -> second ap_start rises only after the first done handshake.
REQ-025 A bench SHALL cover: cont_stall=1 for 5 cycles while ap_done=1 -> ap_continue=0 and txn_done unchanged; release -> txn_done+1 on the first cycle.
REQ-026 A bench SHALL cover: final start handshake and an earlier invocation's done handshake in the same cycle -> both counters advance and outstanding is unchanged.
REQ-027 A bench SHALL cover: cmd_count=0 -> all_done pulse next cycle, busy stays 0, no ap_start.
REQ-028 A bench SHALL cover: reset asserted in RUN after 2 of 5 starts -> next edge IDLE, ap_start=0, counters 0, no all_done; a new cmd_count=1 batch completes normally.
